// File: rtl/cursor_arbiter_pkg.sv
// Shared types and helpers for the cursor overlay arbiter.
// Coordinates are 12-bit unsigned screen positions.
package cursor_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARB    = 2'd1,
      CLAMP  = 2'd2,
      COMMIT = 2'd3
   } cursor_state_t;

   typedef logic [11:0] coord_t;

   localparam int NUM_REQ = 2;

   function automatic coord_t clamp_coord(input coord_t v, input coord_t lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/cursor_arbiter_if.sv
// Requester handshakes and committed cursor position, bundled as one port.
// master = requesters + drawing stage, slave = the arbiter.
interface cursor_arbiter_if;
   import cursor_pkg::*;

   logic   req0;
   coord_t x0;
   coord_t y0;
   logic   ack0;
   logic   req1;
   coord_t x1;
   coord_t y1;
   logic   ack1;
   coord_t xpos;
   coord_t ypos;
   logic   owner;
   logic   upd;

   modport master (
      output req0, x0, y0, req1, x1, y1,
      input  ack0, ack1, xpos, ypos, owner, upd
   );

   modport slave (
      input  req0, x0, y0, req1, x1, y1,
      output ack0, ack1, xpos, ypos, owner, upd
   );

endinterface

// File: rtl/cursor_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: combinational choice, pointer flop that
// moves to the other index whenever a grant is committed.
module rr_arbiter2
   import cursor_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               commit,
   input  logic               commit_id,
   output logic               grant_valid,
   output logic               grant_id
);

   logic ptr_r;

   // Pointer register: after any commit the other index wins the next tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_r <= 1'b0;
      end else if (commit) begin
         ptr_r <= ~commit_id;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Grant selection: lone requester wins, ties go to the pointer.
   always_comb begin
      grant_valid = |req;
      grant_id    = 1'b0;
      case (req)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ptr_r;
         default: grant_id = 1'b0;
      endcase
   end

endmodule

// File: rtl/cursor_arbiter.sv
// Frame-synchronous cursor position arbiter: one round-robin grant per
// frame, clamped to the visible area, committed at the start of vblank.
module cursor_arbiter
   import cursor_pkg::*;
#(
   parameter int H_ACTIVE = 800,
   parameter int V_ACTIVE = 600,
   parameter int CURSOR_W = 16,
   parameter int CURSOR_H = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             vblnk,
   cursor_arbiter_if.slave  bus
);

   localparam coord_t X_MAX = coord_t'(H_ACTIVE - CURSOR_W);
   localparam coord_t Y_MAX = coord_t'(V_ACTIVE - CURSOR_H);

   cursor_state_t        state_r;
   cursor_state_t        state_s;
   logic                 vblnk_d_r;
   logic                 tick_s;
   logic [NUM_REQ-1:0]   req_s;
   logic                 grant_valid_s;
   logic                 grant_id_s;
   logic                 commit_s;
   logic                 grant_r;
   coord_t               x_raw_r;
   coord_t               y_raw_r;
   coord_t               xc_r;
   coord_t               yc_r;
   coord_t               xpos_r;
   coord_t               ypos_r;
   logic                 owner_r;
   logic                 upd_r;
   logic                 ack0_r;
   logic                 ack1_r;

   assign req_s    = {bus.req1, bus.req0};
   assign tick_s   = vblnk & ~vblnk_d_r;
   assign commit_s = (state_r == COMMIT);

   rr_arbiter2 u_rr (
      .clk         (clk),
      .rst         (rst),
      .req         (req_s),
      .commit      (commit_s),
      .commit_id   (grant_r),
      .grant_valid (grant_valid_s),
      .grant_id    (grant_id_s)
   );

   // Frame edge detector and FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vblnk_d_r <= 1'b0;
         state_r   <= IDLE;
      end else begin
         vblnk_d_r <= vblnk;
         state_r   <= state_s;
      end
   end

   // Next-state logic; a tick outside IDLE is deliberately ignored.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = tick_s ? ARB : IDLE;
         ARB:     state_s = grant_valid_s ? CLAMP : IDLE;
         CLAMP:   state_s = COMMIT;
         COMMIT:  state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Datapath: capture the granted request, clamp it, then commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_r <= 1'b0;
         x_raw_r <= 12'd0;
         y_raw_r <= 12'd0;
         xc_r    <= 12'd0;
         yc_r    <= 12'd0;
         xpos_r  <= 12'd0;
         ypos_r  <= 12'd0;
         owner_r <= 1'b0;
         upd_r   <= 1'b0;
         ack0_r  <= 1'b0;
         ack1_r  <= 1'b0;
      end else begin
         upd_r  <= 1'b0;
         ack0_r <= 1'b0;
         ack1_r <= 1'b0;
         case (state_r)
            ARB: begin
               if (grant_valid_s) begin
                  grant_r <= grant_id_s;
                  x_raw_r <= grant_id_s ? bus.x1 : bus.x0;
                  y_raw_r <= grant_id_s ? bus.y1 : bus.y0;
               end else begin
                  grant_r <= grant_r;
               end
            end
            CLAMP: begin
               xc_r <= clamp_coord(x_raw_r, X_MAX);
               yc_r <= clamp_coord(y_raw_r, Y_MAX);
            end
            COMMIT: begin
               xpos_r  <= xc_r;
               ypos_r  <= yc_r;
               owner_r <= grant_r;
               upd_r   <= 1'b1;
               ack0_r  <= (grant_r == 1'b0);
               ack1_r  <= (grant_r == 1'b1);
            end
            default: begin
               grant_r <= grant_r;
            end
         endcase
      end
   end

   assign bus.xpos  = xpos_r;
   assign bus.ypos  = ypos_r;
   assign bus.owner = owner_r;
   assign bus.upd   = upd_r;
   assign bus.ack0  = ack0_r;
   assign bus.ack1  = ack1_r;

endmodule

// File: tb/tb_cursor_arbiter.sv
// Scoreboard bench for cursor_arbiter: stimulus pushes expected commits,
// a monitor pops and checks them whenever upd/ack fire.
module tb_cursor_arbiter;
   import cursor_pkg::*;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      logic        own;
   } exp_t;

   logic clk;
   logic rst;
   logic vblnk;
   int   n_cmp;
   int   n_err;
   exp_t exp_q[$];

   cursor_arbiter_if bus ();

   cursor_arbiter #(
      .H_ACTIVE (800),
      .V_ACTIVE (600),
      .CURSOR_W (16),
      .CURSOR_H (16)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .vblnk (vblnk),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, n_cmp=%0d n_err=%0d", n_cmp, n_err);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every upd/ack cycle must match the head of the queue.
   always @(negedge clk) begin
      if (rst && (bus.upd || bus.ack0 || bus.ack1)) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_commit: upd=%0b ack0=%0b ack1=%0b xpos=%0d, no commit expected",
                     bus.upd, bus.ack0, bus.ack1, bus.xpos);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("xpos",  bus.xpos, e.x);
            chk("ypos",  bus.ypos, e.y);
            chk("owner", {11'd0, bus.owner}, {11'd0, e.own});
            chk("upd",   {11'd0, bus.upd}, 12'd1);
            chk("ack0",  {11'd0, bus.ack0}, {11'd0, ~e.own});
            chk("ack1",  {11'd0, bus.ack1}, {11'd0, e.own});
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic expect_commit(input logic [11:0] x, input logic [11:0] y, input logic own);
      exp_t e;
      e.x = x;
      e.y = y;
      e.own = own;
      exp_q.push_back(e);
   endtask

   task automatic frame(input int hi);
      @(negedge clk);
      vblnk = 1'b1;
      repeat (hi) @(negedge clk);
      vblnk = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      #2;
      while (exp_q.size() != 0 && k < 30) begin
         @(negedge clk);
         #2;
         k++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_timeout: %0d commits still outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      vblnk = 1'b0;
      bus.req0 = 1'b0; bus.x0 = 12'd0; bus.y0 = 12'd0;
      bus.req1 = 1'b0; bus.x1 = 12'd0; bus.y1 = 12'd0;
      repeat (2) @(negedge clk);
      chk("rst_xpos",  bus.xpos, 12'd0);
      chk("rst_ypos",  bus.ypos, 12'd0);
      chk("rst_owner", {11'd0, bus.owner}, 12'd0);
      chk("rst_upd",   {11'd0, bus.upd}, 12'd0);
      chk("rst_ack0",  {11'd0, bus.ack0}, 12'd0);
      chk("rst_ack1",  {11'd0, bus.ack1}, 12'd0);
      rst = 1'b1;
      @(negedge clk);

      // 1: single local request
      bus.req0 = 1'b1; bus.x0 = 12'd100; bus.y0 = 12'd200;
      expect_commit(12'd100, 12'd200, 1'b0);
      frame(8);
      drain("t1");
      bus.req0 = 1'b0;

      // 2: both requesting, alternate 0,1,0 from a fresh pointer
      do_reset();
      bus.req0 = 1'b1; bus.x0 = 12'd10; bus.y0 = 12'd11;
      bus.req1 = 1'b1; bus.x1 = 12'd20; bus.y1 = 12'd21;
      expect_commit(12'd10, 12'd11, 1'b0);
      expect_commit(12'd20, 12'd21, 1'b1);
      expect_commit(12'd10, 12'd11, 1'b0);
      repeat (3) frame(8);
      drain("t2");
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;

      // 3: clamping at and beyond the visible limits
      bus.req1 = 1'b1; bus.x1 = 12'hFFF; bus.y1 = 12'd700;
      expect_commit(12'd784, 12'd584, 1'b1);
      frame(8);
      drain("t3a");
      bus.x1 = 12'd784; bus.y1 = 12'd584;
      expect_commit(12'd784, 12'd584, 1'b1);
      frame(8);
      drain("t3b");
      bus.x1 = 12'd783; bus.y1 = 12'd585;
      expect_commit(12'd783, 12'd584, 1'b1);
      frame(8);
      drain("t3c");
      bus.req1 = 1'b0;

      // 4: idle frames hold the last commit
      bus.req0 = 1'b1; bus.x0 = 12'd50; bus.y0 = 12'd60;
      expect_commit(12'd50, 12'd60, 1'b0);
      frame(8);
      drain("t4");
      bus.req0 = 1'b0;
      repeat (2) frame(8);
      chk("hold_xpos", bus.xpos, 12'd50);
      chk("hold_ypos", bus.ypos, 12'd60);

      // 5: long vblank yields a single commit
      bus.req0 = 1'b1; bus.x0 = 12'd5; bus.y0 = 12'd6;
      expect_commit(12'd5, 12'd6, 1'b0);
      frame(1000);
      drain("t5");
      bus.req0 = 1'b0;

      // 6: reset while in CLAMP, request re-served afterwards
      do_reset();
      bus.req0 = 1'b1; bus.x0 = 12'd300; bus.y0 = 12'd400;
      @(negedge clk);
      vblnk = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_xpos", bus.xpos, 12'd0);
      chk("mid_rst_ack0", {11'd0, bus.ack0}, 12'd0);
      chk("mid_rst_upd",  {11'd0, bus.upd}, 12'd0);
      vblnk = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_xpos", bus.xpos, 12'd0);
      expect_commit(12'd300, 12'd400, 1'b0);
      frame(8);
      drain("t6");
      bus.req0 = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
